// File: rtl/apb_pwm_multi.sv
// ---------------------------------------------------------------------------
// apb_pwm_multi
//
// Multi-channel PWM generator with an APB slave register interface.
// All channels share one prescaler, one period counter and one PERIOD
// value; each channel has its own DUTY value.
//
// PERIOD and DUTY writes land in shadow registers. The active copies that
// drive the comparators are refreshed only at a period boundary (counter
// wrap) or when EN goes 0->1, so a period in progress is never distorted.
//
// Compile-time option:
//   PWM_FADE_EN - when defined, the active duty of each channel steps by 1
//                 toward its shadow (target) value at every period boundary
//                 instead of jumping straight to it. Enabling still loads
//                 the active duty directly from the shadow.
//
// Parameters:
//   NCH        - number of PWM channels (1..8)
//   PWM_W      - width of counter, PERIOD and DUTY (4..16)
//   PRESCALE_W - width of the prescaler register (up to 32)
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESET   in   asynchronous active-high reset
//   PSEL     in   APB select
//   PENABLE  in   APB access phase
//   PWRITE   in   APB direction (1 = write)
//   PADDR    in   APB byte address [7:0], decoded on [7:2]
//   PWDATA   in   APB write data [31:0]
//   PRDATA   out  APB read data, registered, loaded in the setup phase
//   PREADY   out  always 1 (zero wait states)
//   PSLVERR  out  access phase to an unmapped address
//   PWM_OUT  out  registered PWM outputs, one per channel
//   TPS      out  debug bus {boundary pulse, cnt[3:0]}
//
// Register map (word index = PADDR[7:2]):
//   0x00 CTRL      bit0 EN, bit1 INV
//   0x04 PERIOD    shadow; counter runs 0..PERIOD
//   0x08 PRESCALE  tick every PRESCALE+1 clocks
//   0x0C STATUS    bit0 BND (set at boundary, write 1 to clear)
//   0x10+4*i       DUTY[i] shadow, i < NCH
//
// Handshake: an APB transfer is a setup cycle (PSEL=1, PENABLE=0) followed
// by one access cycle (PSEL=1, PENABLE=1). PREADY is constantly 1, so every
// access cycle completes; writes take effect at the end of the access cycle
// and read data is registered at the end of the setup cycle.
// ---------------------------------------------------------------------------
module apb_pwm_multi #(
    parameter int NCH        = 3,
    parameter int PWM_W      = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  logic [7:0]      PADDR,
    input  logic [31:0]     PWDATA,
    output logic [31:0]     PRDATA,
    output logic            PREADY,
    output logic            PSLVERR,
    output logic [NCH-1:0]  PWM_OUT,
    output logic [4:0]      TPS
);

    localparam logic [5:0] IDX_CTRL     = 6'd0;
    localparam logic [5:0] IDX_PERIOD   = 6'd1;
    localparam logic [5:0] IDX_PRESCALE = 6'd2;
    localparam logic [5:0] IDX_STATUS   = 6'd3;
    localparam logic [5:0] IDX_DUTY0    = 6'd4;
    localparam logic [5:0] IDX_DUTY_END = 6'(4 + NCH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  en_q, en_d;
    logic                  inv_q, inv_d;
    logic                  bnd_q, bnd_d;
    logic                  bnd_pulse_q, bnd_pulse_d;
    logic [PWM_W-1:0]      period_sh_q, period_sh_d;
    logic [PWM_W-1:0]      period_act_q, period_act_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [PWM_W-1:0]      cnt_q, cnt_d;
    logic [PWM_W-1:0]      duty_sh_q  [NCH];
    logic [PWM_W-1:0]      duty_sh_d  [NCH];
    logic [PWM_W-1:0]      duty_act_q [NCH];
    logic [PWM_W-1:0]      duty_act_d [NCH];
    logic [NCH-1:0]        pwm_out_q, pwm_out_d;
    logic [31:0]           prdata_q, prdata_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0]  reg_idx;
    logic        addr_mapped;
    logic        setup_rd;
    logic        access;
    logic        wr_en;
    logic        en_rise;
    logic        tick;
    logic        boundary;
    logic [31:0] rdata_mux;
    logic        unused_bits;

    assign reg_idx  = PADDR[7:2];
    assign setup_rd = PSEL && !PENABLE && !PWRITE;
    assign access   = PSEL && PENABLE;
    assign wr_en    = access && PWRITE && addr_mapped;

    // Byte-lane bits of the address and the write-data bits above each
    // register's width carry no information.
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_comb begin
        addr_mapped = (reg_idx < IDX_DUTY0) ||
                      ((reg_idx >= IDX_DUTY0) && (reg_idx < IDX_DUTY_END));
    end

    // Read mux; unmapped addresses read as 0, narrow registers zero-extend.
    always_comb begin
        rdata_mux = 32'd0;
        case (reg_idx)
            IDX_CTRL:     rdata_mux = {30'd0, inv_q, en_q};
            IDX_PERIOD:   rdata_mux = 32'(period_sh_q);
            IDX_PRESCALE: rdata_mux = 32'(prescale_q);
            IDX_STATUS:   rdata_mux = {31'd0, bnd_q};
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (reg_idx == IDX_DUTY0 + 6'(i)) begin
                        rdata_mux = 32'(duty_sh_q[i]);
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        en_d         = en_q;
        inv_d        = inv_q;
        bnd_d        = bnd_q;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        prescale_d   = prescale_q;
        pcnt_d       = pcnt_q;
        cnt_d        = cnt_q;
        duty_sh_d    = duty_sh_q;
        duty_act_d   = duty_act_q;
        tick         = 1'b0;
        boundary     = 1'b0;
        en_rise      = 1'b0;

        // Register writes
        if (wr_en) begin
            case (reg_idx)
                IDX_CTRL: begin
                    en_d    = PWDATA[0];
                    inv_d   = PWDATA[1];
                    en_rise = PWDATA[0] && !en_q;
                end
                IDX_PERIOD:   period_sh_d = PWDATA[PWM_W-1:0];
                IDX_PRESCALE: prescale_d  = PWDATA[PRESCALE_W-1:0];
                IDX_STATUS: begin
                    if (PWDATA[0]) begin
                        bnd_d = 1'b0;
                    end
                end
                default: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (reg_idx == IDX_DUTY0 + 6'(i)) begin
                            duty_sh_d[i] = PWDATA[PWM_W-1:0];
                        end
                    end
                end
            endcase
        end

        // Prescaler and period counter. ">=" on the prescaler keeps it from
        // running the full counter range if PRESCALE is lowered below pcnt.
        if (!en_q) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else begin
            if (pcnt_q >= prescale_q) begin
                pcnt_d = '0;
                tick   = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
            if (tick) begin
                if (cnt_q == period_act_q) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Boundary set is evaluated after the W1C so that set wins.
        if (boundary) begin
            bnd_d = 1'b1;
        end

        // Active copies: enable loads everything directly; a boundary loads
        // PERIOD directly and DUTY either directly or one step at a time.
        if (en_rise || boundary) begin
            period_act_d = period_sh_q;
        end
        if (en_rise) begin
            duty_act_d = duty_sh_q;
        end else if (boundary) begin
`ifdef PWM_FADE_EN
            for (int i = 0; i < NCH; i++) begin
                if (duty_act_q[i] < duty_sh_q[i]) begin
                    duty_act_d[i] = duty_act_q[i] + 1'b1;
                end else if (duty_act_q[i] > duty_sh_q[i]) begin
                    duty_act_d[i] = duty_act_q[i] - 1'b1;
                end
            end
`else
            duty_act_d = duty_sh_q;
`endif
        end
    end

    // Outputs are computed from the current counter and registered, giving
    // one cycle of latency. DUTY > PERIOD makes the compare always true.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (en_q) begin
                pwm_out_d[i] = (cnt_q < duty_act_q[i]) ^ inv_q;
            end else begin
                pwm_out_d[i] = inv_q;
            end
        end
        bnd_pulse_d = boundary;
        prdata_d    = setup_rd ? rdata_mux : prdata_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q         <= 1'b0;
            inv_q        <= 1'b0;
            bnd_q        <= 1'b0;
            bnd_pulse_q  <= 1'b0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            prescale_q   <= '0;
            pcnt_q       <= '0;
            cnt_q        <= '0;
            pwm_out_q    <= '0;
            prdata_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            en_q         <= en_d;
            inv_q        <= inv_d;
            bnd_q        <= bnd_d;
            bnd_pulse_q  <= bnd_pulse_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            prescale_q   <= prescale_d;
            pcnt_q       <= pcnt_d;
            cnt_q        <= cnt_d;
            pwm_out_q    <= pwm_out_d;
            prdata_q     <= prdata_d;
            for (int i = 0; i < NCH; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = 1'b1;
    // Held low during reset even if a master is mid-transfer.
    assign PSLVERR = access && !addr_mapped && !PRESET;
    assign PWM_OUT = pwm_out_q;
    assign TPS     = {bnd_pulse_q, cnt_q[3:0]};

endmodule
